// File: rtl/sd_cmd_resp_rx_if.sv
// rtl/sd_cmd_resp_rx_if.sv - CMD response receiver bundle; SD_CMD_RESP_RX_R1B_EN adds dat0_i/wait_busy
interface sd_cmd_resp_rx_if;
    logic         bit_en;
    logic         cmd_i;
    logic         start;
    logic         long_resp;
    logic         check_crc;
    logic         busy;
    logic         done;
    logic [5:0]   index;
    logic [119:0] resp;
    logic [6:0]   crc_rx;
    logic         crc_err;
    logic         trans_err;
    logic         end_err;
    logic         timeout_err;
`ifdef SD_CMD_RESP_RX_R1B_EN
    logic         dat0_i;
    logic         wait_busy;

    modport master (
        output bit_en, cmd_i, start, long_resp, check_crc, dat0_i, wait_busy,
        input  busy, done, index, resp, crc_rx, crc_err, trans_err, end_err, timeout_err
    );
    modport slave (
        input  bit_en, cmd_i, start, long_resp, check_crc, dat0_i, wait_busy,
        output busy, done, index, resp, crc_rx, crc_err, trans_err, end_err, timeout_err
    );
`else
    modport master (
        output bit_en, cmd_i, start, long_resp, check_crc,
        input  busy, done, index, resp, crc_rx, crc_err, trans_err, end_err, timeout_err
    );
    modport slave (
        input  bit_en, cmd_i, start, long_resp, check_crc,
        output busy, done, index, resp, crc_rx, crc_err, trans_err, end_err, timeout_err
    );
`endif
endinterface

// File: rtl/sd_cmd_resp_rx.sv
// rtl/sd_cmd_resp_rx.sv - SD CMD line response deserialiser with CRC7 check; optional R1b busy wait under SD_CMD_RESP_RX_R1B_EN
module sd_cmd_resp_rx #(
    parameter int NCR_MAX = 64,
    parameter int TO_W    = 8
) (
    input  logic             clk,
    input  logic             rst,
    sd_cmd_resp_rx_if.slave  bus
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_RECV
`ifdef SD_CMD_RESP_RX_R1B_EN
        , S_BUSYW
`endif
    } state_t;

    localparam logic [TO_W-1:0] NCR_LAST = TO_W'(NCR_MAX - 1);

    state_t          state_q, state_d;
    logic            long_q, chk_q;
    logic [6:0]      crc_q;
    logic [TO_W-1:0] to_cnt;
    logic [7:0]      bit_cnt;
    logic [119:0]    shreg;

    logic            busy_q, done_q;
    logic [5:0]      index_q;
    logic [119:0]    resp_q;
    logic [6:0]      crc_rx_q;
    logic            crc_err_q, trans_err_q, end_err_q, timeout_err_q;

    logic            to_hit, first_bit, last_bit, in_data, in_crc, feed_crc;
    logic            end_to_busyw, finish;

    function automatic logic [6:0] crc7_step(input logic [6:0] c, input logic b);
        logic inv;
        inv = b ^ c[6];
        return {c[5:3], c[2] ^ inv, c[1:0], inv};
    endfunction

    // bit_cnt holds the frame bit index of the next bit to arrive
    assign to_hit    = (to_cnt >= NCR_LAST);
    assign first_bit = (bit_cnt == (long_q ? 8'd134 : 8'd46));
    assign last_bit  = (bit_cnt == 8'd0);
    assign in_crc    = (bit_cnt >= 8'd1) && (bit_cnt <= 8'd7);
    assign in_data   = (bit_cnt >= 8'd8) && (bit_cnt <= (long_q ? 8'd127 : 8'd45));
    assign feed_crc  = (bit_cnt >= 8'd8) && (!long_q || (bit_cnt <= 8'd127));

`ifdef SD_CMD_RESP_RX_R1B_EN
    logic wb_q;
    assign end_to_busyw = wb_q;
`else
    assign end_to_busyw = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        finish  = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (bus.start) state_d = S_WAIT;
            end
            S_WAIT: begin
                if (bus.bit_en) begin
                    if (!bus.cmd_i) begin
                        state_d = S_RECV;
                    end else if (to_hit) begin
                        state_d = S_IDLE;
                        finish  = 1'b1;
                    end
                end
            end
            S_RECV: begin
                if (bus.bit_en && last_bit) begin
`ifdef SD_CMD_RESP_RX_R1B_EN
                    state_d = end_to_busyw ? S_BUSYW : S_IDLE;
`else
                    state_d = S_IDLE;
`endif
                    finish  = !end_to_busyw;
                end
            end
`ifdef SD_CMD_RESP_RX_R1B_EN
            S_BUSYW: begin
                if (bus.bit_en && bus.dat0_i) begin
                    state_d = S_IDLE;
                    finish  = 1'b1;
                end
            end
`endif
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) state_q <= S_IDLE;
        else     state_q <= state_d;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            long_q        <= 1'b0;
            chk_q         <= 1'b0;
            crc_q         <= '0;
            to_cnt        <= '0;
            bit_cnt       <= '0;
            shreg         <= '0;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
            index_q       <= '0;
            resp_q        <= '0;
            crc_rx_q      <= '0;
            crc_err_q     <= 1'b0;
            trans_err_q   <= 1'b0;
            end_err_q     <= 1'b0;
            timeout_err_q <= 1'b0;
`ifdef SD_CMD_RESP_RX_R1B_EN
            wb_q          <= 1'b0;
`endif
        end else begin
            done_q <= finish;
            if (finish) busy_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (bus.start) begin
                        long_q        <= bus.long_resp;
                        chk_q         <= bus.check_crc;
`ifdef SD_CMD_RESP_RX_R1B_EN
                        wb_q          <= bus.wait_busy;
`endif
                        crc_q         <= '0;
                        to_cnt        <= '0;
                        shreg         <= '0;
                        busy_q        <= 1'b1;
                        index_q       <= '0;
                        resp_q        <= '0;
                        crc_rx_q      <= '0;
                        crc_err_q     <= 1'b0;
                        trans_err_q   <= 1'b0;
                        end_err_q     <= 1'b0;
                        timeout_err_q <= 1'b0;
                    end
                end
                S_WAIT: begin
                    if (bus.bit_en) begin
                        if (bus.cmd_i) begin
                            if (to_hit)             timeout_err_q <= 1'b1;
                            else if (to_cnt != '1)  to_cnt <= to_cnt + 1'b1;
                        end else begin
                            if (!long_q) crc_q <= crc7_step(crc_q, 1'b0);
                            bit_cnt <= long_q ? 8'd134 : 8'd46;
                        end
                    end
                end
                S_RECV: begin
                    if (bus.bit_en) begin
                        bit_cnt <= bit_cnt - 8'd1;
                        if (feed_crc)  crc_q    <= crc7_step(crc_q, bus.cmd_i);
                        if (in_data)   shreg    <= {shreg[118:0], bus.cmd_i};
                        if (in_crc)    crc_rx_q <= {crc_rx_q[5:0], bus.cmd_i};
                        if (first_bit) trans_err_q <= bus.cmd_i;
                        if (last_bit) begin
                            end_err_q <= ~bus.cmd_i;
                            crc_err_q <= chk_q & (crc_q != crc_rx_q);
                            resp_q    <= long_q ? shreg : {88'b0, shreg[31:0]};
                            index_q   <= long_q ? 6'h3F : shreg[37:32];
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.busy        = busy_q;
    assign bus.done        = done_q;
    assign bus.index       = index_q;
    assign bus.resp        = resp_q;
    assign bus.crc_rx      = crc_rx_q;
    assign bus.crc_err     = crc_err_q;
    assign bus.trans_err   = trans_err_q;
    assign bus.end_err     = end_err_q;
    assign bus.timeout_err = timeout_err_q;

endmodule

// File: tb/tb_sd_cmd_resp_rx.sv
// tb/tb_sd_cmd_resp_rx.sv - scoreboard bench for sd_cmd_resp_rx
module tb_sd_cmd_resp_rx;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    sd_cmd_resp_rx_if bus ();

    sd_cmd_resp_rx #(.NCR_MAX(64), .TO_W(8)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        logic [5:0]   index;
        logic [119:0] resp;
        logic [6:0]   crc_rx;
        logic         crc_err;
        logic         trans_err;
        logic         end_err;
        logic         timeout_err;
    } exp_t;

    exp_t sb[$];
    int   n_pass = 0;
    int   n_chk  = 0;

    localparam logic [47:0] R7     = 48'h08_0000_01AA_13;
    localparam logic [47:0] R7_BAD = 48'h08_0000_01AB_13;
    localparam logic [47:0] R3     = 48'h3F_80FF_8000_FF;

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_chk++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    endtask

    task automatic exp_push(input logic [5:0] idx, input logic [119:0] r, input logic [6:0] c,
                            input logic ce, input logic te, input logic ee, input logic to);
        exp_t e;
        e.index = idx; e.resp = r; e.crc_rx = c;
        e.crc_err = ce; e.trans_err = te; e.end_err = ee; e.timeout_err = to;
        sb.push_back(e);
    endtask

    // Textbook shift-left CRC7 (generator 0x09) over frame bits hi..lo
    function automatic logic [6:0] crc7_ref(input logic [135:0] f, input int hi, input int lo);
        logic [6:0] c;
        logic fb;
        c = '0;
        for (int i = hi; i >= lo; i--) begin
            fb = f[i] ^ c[6];
            c  = c << 1;
            if (fb) c = c ^ 7'h09;
        end
        return c;
    endfunction

    always @(negedge clk) begin
        if (bus.done) begin
            if (sb.size() == 0) begin
                check("spurious_done", 128'(bus.done), 128'd0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("index",       128'(bus.index),       128'(e.index));
                check("resp",        128'(bus.resp),        128'(e.resp));
                check("crc_rx",      128'(bus.crc_rx),      128'(e.crc_rx));
                check("crc_err",     128'(bus.crc_err),     128'(e.crc_err));
                check("trans_err",   128'(bus.trans_err),   128'(e.trans_err));
                check("end_err",     128'(bus.end_err),     128'(e.end_err));
                check("timeout_err", 128'(bus.timeout_err), 128'(e.timeout_err));
            end
        end
    end

    // Random idle gap with junk on cmd_i, then one bit_en strobe carrying b
    task automatic strobe(input logic b);
        int gap;
        gap = $urandom_range(0, 2);
        repeat (gap) begin
            @(posedge clk); #1;
            bus.bit_en = 1'b0;
            bus.cmd_i  = 1'($urandom);
        end
        @(posedge clk); #1;
        bus.bit_en = 1'b1;
        bus.cmd_i  = b;
        @(posedge clk); #1;
        bus.bit_en = 1'b0;
        bus.cmd_i  = 1'($urandom);
    endtask

    task automatic idle_ones(input int n);
        for (int i = 0; i < n; i++) strobe(1'b1);
    endtask

    task automatic send(input logic [135:0] f, input int hi, input int lo);
        for (int i = hi; i >= lo; i--) strobe(f[i]);
    endtask

    // Start pulse; be=1 also raises bit_en with cmd_i=0, which must not count as a start bit
    task automatic start_pulse(input logic lr, input logic cc, input logic be);
        @(posedge clk); #1;
        bus.start     = 1'b1;
        bus.long_resp = lr;
        bus.check_crc = cc;
        bus.bit_en    = be;
        bus.cmd_i     = 1'b0;
        @(posedge clk); #1;
        bus.start     = 1'b0;
        bus.bit_en    = 1'b0;
        bus.long_resp = 1'($urandom);
        bus.check_crc = 1'($urandom);
    endtask

    task automatic r7_frame(input logic be);
        exp_push(6'h08, 120'h1AA, 7'h09, 1'b0, 1'b0, 1'b0, 1'b0);
        start_pulse(1'b0, 1'b1, be);
        idle_ones(4);
        send(136'(R7), 47, 0);
        @(negedge clk);
        check("r7_done_lat", 128'(bus.done), 128'd1);
        check("r7_busy_low", 128'(bus.busy), 128'd0);
    endtask

    initial begin
        logic [135:0] r2;
        logic [6:0]   r2_crc;

        bus.bit_en = 1'b0; bus.cmd_i = 1'b1; bus.start = 1'b0;
        bus.long_resp = 1'b0; bus.check_crc = 1'b0;
`ifdef SD_CMD_RESP_RX_R1B_EN
        bus.dat0_i = 1'b1; bus.wait_busy = 1'b0;
`endif
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("rst_busy",    128'(bus.busy),        128'd0);
        check("rst_done",    128'(bus.done),        128'd0);
        check("rst_index",   128'(bus.index),       128'd0);
        check("rst_resp",    128'(bus.resp),        128'd0);
        check("rst_crc_rx",  128'(bus.crc_rx),      128'd0);
        check("rst_errs",    128'({bus.crc_err, bus.trans_err, bus.end_err, bus.timeout_err}), 128'd0);

        r7_frame(1'b1);

        exp_push(6'h08, 120'h1AB, 7'h09, 1'b1, 1'b0, 1'b0, 1'b0);
        start_pulse(1'b0, 1'b1, 1'b0);
        idle_ones(4);
        send(136'(R7_BAD), 47, 0);

        exp_push(6'h3F, 120'h80FF8000, 7'h7F, 1'b0, 1'b0, 1'b0, 1'b0);
        start_pulse(1'b0, 1'b0, 1'b0);
        idle_ones(2);
        send(136'(R3), 47, 0);

        exp_push(6'h00, 120'h0, 7'h00, 1'b0, 1'b0, 1'b0, 1'b1);
        start_pulse(1'b0, 1'b1, 1'b0);
        idle_ones(63);
        @(negedge clk);
        check("to_63_no_done", 128'(bus.done), 128'd0);
        check("to_63_busy",    128'(bus.busy), 128'd1);
        strobe(1'b1);
        @(negedge clk);
        check("to_64_done", 128'(bus.done),        128'd1);
        check("to_64_flag", 128'(bus.timeout_err), 128'd1);

        exp_push(6'h08, 120'h1AA, 7'h09, 1'b0, 1'b0, 1'b0, 1'b0);
        start_pulse(1'b0, 1'b1, 1'b0);
        @(negedge clk);
        check("restart_clr_to", 128'(bus.timeout_err), 128'd0);
        check("restart_busy",   128'(bus.busy),        128'd1);
        idle_ones(3);
        send(136'(R7), 47, 0);

        r2 = '0;
        r2[133:128] = 6'h3F;
        r2[127:8]   = {15{8'hA5}};
        r2_crc      = crc7_ref(r2, 127, 8);
        r2[7:1]     = r2_crc;
        r2[0]       = 1'b0;
        exp_push(6'h3F, {15{8'hA5}}, r2_crc, 1'b0, 1'b0, 1'b1, 1'b0);
        start_pulse(1'b1, 1'b1, 1'b0);
        idle_ones(2);
        send(r2, 135, 0);
        @(negedge clk);
        check("r2_done_lat", 128'(bus.done), 128'd1);

        start_pulse(1'b0, 1'b1, 1'b0);
        idle_ones(4);
        send(136'(R7), 47, 28);
        @(posedge clk); #1 rst = 1'b1;
        @(posedge clk); #1 rst = 1'b0;
        @(negedge clk);
        check("midrst_busy",   128'(bus.busy),   128'd0);
        check("midrst_crc_rx", 128'(bus.crc_rx), 128'd0);
        r7_frame(1'b0);

        exp_push(6'h08, 120'h1AA, 7'h09, 1'b0, 1'b0, 1'b0, 1'b0);
        start_pulse(1'b0, 1'b1, 1'b0);
        idle_ones(4);
        send(136'(R7), 47, 38);
        start_pulse(1'b1, 1'b0, 1'b0);
        @(negedge clk);
        check("busy_start_ign", 128'(bus.busy), 128'd1);
        send(136'(R7), 37, 0);
        @(negedge clk);
        check("busy_start_done", 128'(bus.done), 128'd1);

        repeat (5) @(posedge clk);
        check("sb_empty", 128'(sb.size()), 128'd0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
